i2c: RTL and testbench

I2C -- requirements
Module: i2c

---
 rtl/i2c_pkg.sv | 9 +
 rtl/i2c_tick_gen.sv | 17 +
 rtl/i2c.sv | 85 ++++++++
 tb/tb_i2c.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and protocol constants for the i2c read controller
//   state_e        : controller FSM states
//   DEF_SLAVE_ADDR : default 7-bit slave address
//   RD_BIT         : R/W bit value for a read
package i2c_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_READ, S_MNACK, S_STOP} state_e;
  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h48;
  localparam logic RD_BIT = 1'b1;
endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: modulo-DIV counter producing one tick per SCL half-period
//   clk  : system clock
//   rst  : synchronous active-high reset
//   tick : one-cycle pulse every DIV clk cycles (constant 1 when DIV=1)
module i2c_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(DIV - 1);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/i2c.sv
// i2c: single-master read-only I2C controller polling one slave byte
//   clk    : system clock
//   rst    : synchronous active-high reset
//   enable : level request to keep running read transactions
//   scl    : push-pull I2C clock
//   vtg    : last byte read from the slave
//   sda    : open-drain I2C data (drives 0 or z only)
module i2c
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter int         DIV        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       scl,
  output logic [7:0] vtg,
  inout  wire        sda
);
  state_e state_q, state_d;
  logic phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d, vtg_q, vtg_d;
  logic tick, sda_in, sda_oe, last;
  logic [7:0] addr_byte;
  assign addr_byte = {SLAVE_ADDR, RD_BIT};
  // a released line may read as z/x; only a solid 0 counts as 0
  assign sda_in = (sda === 1'b0) ? 1'b0 : 1'b1;
  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign vtg = vtg_q;
  assign last = bit_q == 3'd7;
  i2c_tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      bit_q   <= '0;
      shreg_q <= '0;
      vtg_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      vtg_q   <= vtg_d;
    end
  end
  // every non-idle state is two ticks long; phase_q selects which half
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    vtg_d   = vtg_q;
    if (tick && state_q != S_IDLE) phase_d = ~phase_q;
    if (tick && state_q == S_IDLE && enable) state_d = S_START;
    if (tick && phase_q) begin
      case (state_q)
        S_START:    state_d = S_ADDR;
        S_ADDR: begin
          bit_d = bit_q + 3'd1;
          if (last) state_d = S_ADDR_ACK;
        end
        S_ADDR_ACK: state_d = sda_in ? S_STOP : S_READ;
        S_READ: begin
          bit_d   = bit_q + 3'd1;
          shreg_d = {shreg_q[6:0], sda_in};
          if (last) begin
            state_d = S_MNACK;
            vtg_d   = {shreg_q[6:0], sda_in};
          end
        end
        S_MNACK:    state_d = S_STOP;
        S_STOP:     state_d = S_IDLE;
        default:    state_d = state_q;
      endcase
    end
  end
  // START holds scl high in its first half; bit slots and STOP raise scl in the second
  always_comb begin
    scl    = state_q == S_IDLE || (state_q == S_START ? !phase_q : phase_q);
    sda_oe = state_q == S_START || state_q == S_STOP || (state_q == S_ADDR && !addr_byte[~bit_q]);
  end
endmodule

// File: tb/tb_i2c.sv
// tb_i2c: randomized bench with bus-level slave and waveform-level reference model for i2c
module tb_i2c;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic scl;
  logic [7:0] vtg;
  wire sda;
  logic slv_drv = 1'b0, sda_v;
  pullup (sda);
  assign sda = slv_drv ? 1'b0 : 1'bz;
  assign sda_v = (sda === 1'b0) ? 1'b0 : 1'b1;
  always #5 clk = ~clk;
  i2c #(.SLAVE_ADDR(7'h48), .DIV(1)) dut (.clk(clk), .rst(rst), .enable(enable), .scl(scl), .vtg(vtg), .sda(sda));
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  // expected bus waveform: one entry per tick; kind 1 = START edge, 2 = STOP tick
  typedef struct packed {logic scl; logic sda; logic ld; logic [1:0] kind;} ent_t;
  ent_t q[$];
  ent_t e_cur;
  logic [7:0] exp_vtg = 8'h00, txn_data = 8'h00, cfg_data = 8'hA5;
  logic txn_present = 1'b0, cfg_present = 1'b1, rst_s = 1'b1, started = 1'b0;
  task automatic push(input logic s, input logic d, input logic ld = 1'b0, input logic [1:0] k = 2'd0);
    q.push_back({s, d, ld, k});
  endtask
  task automatic load();
    logic [7:0] a = {7'h48, 1'b1};
    txn_present = cfg_present;
    txn_data = cfg_data;
    push(1, 0, 0, 2'd1);
    push(0, 0);
    for (int i = 7; i >= 0; i--) begin
      push(0, a[i]);
      push(1, a[i]);
    end
    push(0, !txn_present);
    push(1, !txn_present);
    if (txn_present) begin
      for (int i = 7; i >= 0; i--) begin
        push(0, txn_data[i]);
        push(1, txn_data[i], i == 0);
      end
      push(0, 1);
      push(1, 1);
    end
    push(0, 0);
    push(1, 0, 0, 2'd2);
  endtask
  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      q.delete();
      exp_vtg = 8'h00;
    end else if (q.size() != 0) begin
      if (q[0].ld) exp_vtg = txn_data;
      void'(q.pop_front());
    end else if (enable) load();
  end
  always @(posedge clk) rst_s <= rst;
  logic p_scl = 1'b1, p_sda = 1'b1, pok;
  logic [1:0] p_kind = 2'd0;
  always @(negedge clk) if (started) begin
    e_cur = q.size() != 0 ? q[0] : 5'b11000;
    chk("scl", 8'(scl), 8'(e_cur.scl));
    chk("sda", 8'(sda_v), 8'(e_cur.sda));
    chk("vtg", vtg, exp_vtg);
    if (!rst_s && p_scl && scl && p_sda != sda_v) begin
      pok = (e_cur.kind == 2'd1 && !sda_v) || (p_kind == 2'd2 && sda_v);
      chk("sda_edge_scl_high", 8'(pok), 8'd1);
    end
    p_scl = scl;
    p_sda = sda_v;
    p_kind = e_cur.kind;
  end
  // bus-level slave: decodes START/STOP and scl edges, ACKs 0x48 reads, returns txn_data
  logic s_scl = 1'b1, s_sda = 1'b1, slv_on = 1'b0, acked = 1'b0;
  int slv_cnt = 0;
  logic [7:0] slv_addr = 8'h00, last_addr = 8'h00;
  always @(posedge clk) begin
    #1;
    if (rst_s) begin
      slv_on = 1'b0;
      slv_drv = 1'b0;
    end else if (s_scl && scl && s_sda && !sda_v) begin
      slv_on = 1'b1;
      slv_cnt = 0;
      acked = 1'b0;
    end else if (s_scl && scl && !s_sda && sda_v) begin
      slv_on = 1'b0;
      slv_drv = 1'b0;
    end else if (slv_on && !s_scl && scl) begin
      slv_cnt++;
      if (slv_cnt <= 8) slv_addr = {slv_addr[6:0], sda_v};
      if (slv_cnt == 8) last_addr = slv_addr;
    end else if (slv_on && s_scl && !scl) begin
      acked = acked || (slv_cnt == 8 && slv_addr == 8'h91 && txn_present);
      slv_drv = (slv_cnt == 8 && acked) ||
                (acked && slv_cnt >= 9 && slv_cnt <= 16 && !txn_data[3'(16 - slv_cnt)]);
    end
    s_scl = scl;
    s_sda = sda_v;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_start();
    logic ok = 1'b0, pv_scl = scl, pv_sda = sda_v;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (pv_scl && pv_sda && scl && !sda_v) ok = 1'b1;
      pv_scl = scl;
      pv_sda = sda_v;
    end
    chk("start_seen", 8'(ok), 8'd1);
  endtask
  task automatic lit(input string name, input logic s, input logic d, input logic [7:0] v);
    chk({name, "_scl"}, 8'(scl), 8'(s));
    chk({name, "_sda"}, 8'(sda_v), 8'(d));
    chk({name, "_vtg"}, vtg, v);
  endtask
  initial begin
    cyc(1);
    lit("reset_mid", 1, 1, 8'h00);
    cyc(1);
    lit("reset_end", 1, 1, 8'h00);
    rst = 1'b0;
    cyc(3);
    lit("idle_after_reset", 1, 1, 8'h00);
    cfg_present = 1'b0;
    enable = 1'b1;
    wait_start();
    cyc(21);
    lit("nack_stop2", 1, 0, 8'h00);
    cyc(1);
    lit("nack_idle", 1, 1, 8'h00);
    cyc(1);
    lit("nack_restart", 1, 0, 8'h00);
    enable = 1'b0;
    cyc(30);
    cfg_present = 1'b1;
    cfg_data = 8'hA5;
    enable = 1'b1;
    wait_start();
    cyc(29);
    chk("vtg_mid_read", vtg, 8'h00);
    enable = 1'b0;
    cyc(8);
    chk("vtg_cycle38", vtg, 8'hA5);
    chk("addr_byte", last_addr, 8'h91);
    cyc(2);
    lit("stop2_cycle40", 1, 0, 8'hA5);
    cyc(1);
    lit("idle_cycle41", 1, 1, 8'hA5);
    cyc(10);
    lit("no_restart", 1, 1, 8'hA5);
    cfg_data = 8'h3C;
    enable = 1'b1;
    wait_start();
    cyc(24);
    rst = 1'b1;
    cyc(1);
    lit("rst_in_read", 1, 1, 8'h00);
    rst = 1'b0;
    wait_start();
    for (int n = 0; n < 80; n++) begin
      enable = $urandom_range(0, 3) != 0;
      cfg_present = $urandom_range(0, 3) != 0;
      cfg_data = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      cyc($urandom_range(1, 60));
    end
    enable = 1'b0;
    cyc(50);
    lit("final_idle", 1, 1, exp_vtg);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
